// File: rtl/midi_voice_allocator.sv
// MIDI voice allocator: maps note-on/off messages onto NUM_VOICES synth voices.
// Optional macro MIDI_VOICE_STEAL_EN lets a note-on steal the oldest voice when all are busy.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_WIDTH  = 8,
    localparam int VW        = $clog2(NUM_VOICES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  msg_valid,
    input  logic [2:0][7:0]       msg_data,
    input  logic [1:0]            msg_len,
    output logic                  msg_ready,
    output logic                  upd_valid,
    output logic [VW-1:0]         upd_voice,
    output logic                  upd_gate,
    output logic [6:0]            upd_note,
    output logic [6:0]            upd_vel,
    input  logic                  upd_ready,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  all_off
);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

    localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

    state_t               state;
    logic [6:0]           voice_note [NUM_VOICES];
    logic [AGE_WIDTH-1:0] voice_age  [NUM_VOICES];

    logic                 cmd_on;
    logic [6:0]           cmd_note;
    logic [6:0]           cmd_vel;
    logic [VW-1:0]        idx;

    logic                 match_found, free_found;
    logic [VW-1:0]        match_idx, free_idx, old_idx;
    logic [AGE_WIDTH-1:0] old_age;

    logic                 nxt_match_found, nxt_free_found;
    logic [VW-1:0]        nxt_match_idx, nxt_free_idx, nxt_old_idx;
    logic [AGE_WIDTH-1:0] nxt_old_age;

    logic                 is_note_on, is_note_off, is_all_off;
    logic                 hit;
    logic [VW-1:0]        tgt;
    logic                 unused_chan;

    // channel nibble is filtered upstream
    assign unused_chan = ^msg_data[0][3:0];

    // classify the incoming message
    always_comb begin
        is_note_on  = (msg_len == 2'd3) && (msg_data[0][7:4] == 4'h9)
                      && (msg_data[2] != 8'd0);
        is_note_off = (msg_len == 2'd3) && ((msg_data[0][7:4] == 4'h8)
                      || ((msg_data[0][7:4] == 4'h9) && (msg_data[2] == 8'd0)));
        is_all_off  = (msg_len >= 2'd2) && (msg_data[0][7:4] == 4'hB)
                      && (msg_data[1] == 8'd123);
    end

    // fold the voice under examination into the running scan trackers
    always_comb begin
        logic                 m_hit, f_hit, o_hit;
        logic                 cur_act;
        logic [6:0]           cur_note;
        logic [AGE_WIDTH-1:0] cur_age;
        cur_act  = voice_active[idx];
        cur_note = voice_note[idx];
        cur_age  = voice_age[idx];
        m_hit = cur_act && (cur_note == cmd_note) && !match_found;
        f_hit = !cur_act && !free_found;
        o_hit = (idx == '0) || (cur_age > old_age);
        nxt_match_found = match_found || m_hit;
        nxt_match_idx   = m_hit ? idx : match_idx;
        nxt_free_found  = free_found || f_hit;
        nxt_free_idx    = f_hit ? idx : free_idx;
        nxt_old_age     = o_hit ? cur_age : old_age;
        nxt_old_idx     = o_hit ? idx : old_idx;
    end

    // pick the target voice from the completed scan
    always_comb begin
        hit = 1'b0;
        tgt = '0;
        if (nxt_match_found) begin
            hit = 1'b1;
            tgt = nxt_match_idx;
        end else if (cmd_on && nxt_free_found) begin
            hit = 1'b1;
            tgt = nxt_free_idx;
        end else if (cmd_on) begin
`ifdef MIDI_VOICE_STEAL_EN
            hit = 1'b1;
            tgt = nxt_old_idx;
`else
            hit = 1'b0;
`endif
        end
    end

    // control FSM, registered outputs and voice state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            msg_ready    <= 1'b0;
            upd_valid    <= 1'b0;
            upd_voice    <= '0;
            upd_gate     <= 1'b0;
            upd_note     <= '0;
            upd_vel      <= '0;
            voice_active <= '0;
            all_off      <= 1'b0;
            cmd_on       <= 1'b0;
            cmd_note     <= '0;
            cmd_vel      <= '0;
            idx          <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            match_idx    <= '0;
            free_idx     <= '0;
            old_idx      <= '0;
            old_age      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_note[i] <= '0;
                voice_age[i]  <= '0;
            end
        end else begin
            all_off <= 1'b0;
            unique case (state)
                IDLE: begin
                    msg_ready <= 1'b1;
                    if (msg_valid && msg_ready) begin
                        cmd_on      <= is_note_on;
                        cmd_note    <= msg_data[1][6:0];
                        cmd_vel     <= msg_data[2][6:0];
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        match_idx   <= '0;
                        free_idx    <= '0;
                        old_idx     <= '0;
                        old_age     <= '0;
                        if (is_note_on || is_note_off) begin
                            state     <= SCAN;
                            msg_ready <= 1'b0;
                        end else if (is_all_off) begin
                            voice_active <= '0;
                            all_off      <= 1'b1;
                            for (int i = 0; i < NUM_VOICES; i++)
                                voice_age[i] <= '0;
                        end
                    end
                end
                SCAN: begin
                    match_found <= nxt_match_found;
                    match_idx   <= nxt_match_idx;
                    free_found  <= nxt_free_found;
                    free_idx    <= nxt_free_idx;
                    old_age     <= nxt_old_age;
                    old_idx     <= nxt_old_idx;
                    idx         <= idx + 1'b1;
                    if (idx == LAST) begin
                        if (hit) begin
                            state     <= ISSUE;
                            upd_valid <= 1'b1;
                            upd_voice <= tgt;
                            upd_gate  <= cmd_on;
                            upd_note  <= cmd_note;
                            upd_vel   <= cmd_on ? cmd_vel : 7'd0;
                        end else begin
                            state     <= IDLE;
                            msg_ready <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (upd_ready) begin
                        upd_valid               <= 1'b0;
                        state                   <= IDLE;
                        msg_ready               <= 1'b1;
                        voice_active[upd_voice] <= upd_gate;
                        voice_note[upd_voice]   <= upd_note;
                        if (upd_gate) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (upd_voice == VW'(i))
                                    voice_age[i] <= '0;
                                else if (voice_active[i] && (voice_age[i] != '1))
                                    voice_age[i] <= voice_age[i] + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    msg_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench for midi_voice_allocator (NUM_VOICES = 8).
// Expected updates are queued by the stimulus and popped by a negedge monitor.
module tb_midi_voice_allocator;

    typedef struct packed {
        logic [2:0] voice;
        logic       gate;
        logic [6:0] note;
        logic [6:0] vel;
    } upd_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           msg_valid;
    logic [2:0][7:0] msg_data;
    logic [1:0]     msg_len;
    logic           msg_ready;
    logic           upd_valid;
    logic [2:0]     upd_voice;
    logic           upd_gate;
    logic [6:0]     upd_note;
    logic [6:0]     upd_vel;
    logic           upd_ready;
    logic [7:0]     voice_active;
    logic           all_off;

    upd_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   all_off_seen = 0;

    midi_voice_allocator #(.NUM_VOICES(8), .AGE_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_len(msg_len),
        .msg_ready(msg_ready),
        .upd_valid(upd_valid), .upd_voice(upd_voice), .upd_gate(upd_gate),
        .upd_note(upd_note), .upd_vel(upd_vel), .upd_ready(upd_ready),
        .voice_active(voice_active), .all_off(all_off)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // pop-and-compare whenever an update handshake is about to happen
    always @(negedge clk) begin
        upd_t got;
        if (all_off === 1'b1) all_off_seen++;
        if (rst === 1'b0 && upd_valid === 1'b1 && upd_ready === 1'b1) begin
            got = '{upd_voice, upd_gate, upd_note, upd_vel};
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_upd: got %0h expected none", got);
            end else begin
                check("upd", got, exp_q.pop_front());
            end
        end
    end

    task automatic expect_upd(int v, int g, int n, int vel);
        upd_t e;
        e.voice = 3'(v);
        e.gate  = 1'(g);
        e.note  = 7'(n);
        e.vel   = 7'(vel);
        exp_q.push_back(e);
    endtask

    task automatic send(logic [7:0] s, logic [7:0] d1, logic [7:0] d2, logic [1:0] len);
        int t = 0;
        while (msg_ready !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) check("send_timeout", 0, 1);
        msg_valid = 1'b1;
        msg_data  = {d2, d1, s};
        msg_len   = len;
        @(posedge clk); #1;
        msg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (msg_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("idle_timeout", 0, 1);
    endtask

    task automatic note_on(int v, int n, int vel);
        expect_upd(v, 1, n, vel);
        send(8'h90, 8'(n), 8'(vel), 2'd3);
        wait_idle();
    endtask

    task automatic cc_all_off(string name);
        int a = all_off_seen;
        send(8'hB0, 8'h7B, 8'h00, 2'd3);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_pulse"}, all_off_seen - a, 1);
        check({name, "_va"}, voice_active, 8'h00);
    endtask

    initial begin
        upd_t stall_exp;
        int   t;
        rst = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_len = '0; upd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_msg_ready", msg_ready, 0);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_va", voice_active, 0);
        check("rst_all_off", all_off, 0);
        check("rst_upd_fields", {upd_voice, upd_gate, upd_note, upd_vel}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", msg_ready, 1);

        note_on(0, 8'h3C, 8'h64);
        check("va_first_on", voice_active, 8'h01);
        expect_upd(0, 0, 8'h3C, 0);
        send(8'h90, 8'h3C, 8'h00, 2'd3);
        wait_idle();
        check("va_vel0_off", voice_active, 8'h00);

        for (int i = 0; i < 8; i++) note_on(i, 60 + i, 8'h40);
        check("va_full", voice_active, 8'hFF);
`ifdef MIDI_VOICE_STEAL_EN
        expect_upd(0, 1, 68, 8'h40);
`endif
        send(8'h90, 8'd68, 8'h40, 2'd3);
        wait_idle();
        check("va_after_9th", voice_active, 8'hFF);

        note_on(2, 62, 8'h50);
        send(8'h80, 8'h10, 8'h00, 2'd3);
        wait_idle();
        check("va_off_nomatch", voice_active, 8'hFF);
        expect_upd(3, 0, 63, 0);
        send(8'h81, 8'd63, 8'h22, 2'd3);
        wait_idle();
        check("va_off_v3", voice_active, 8'hF7);
        note_on(3, 70, 8'h20);
        check("va_refill", voice_active, 8'hFF);

        send(8'hF8, 8'h00, 8'h00, 2'd1);
        send(8'h90, 8'h30, 8'h00, 2'd2);
        repeat (12) @(posedge clk);
        #1;
        check("va_discard", voice_active, 8'hFF);
        cc_all_off("cc_full");

        note_on(0, 8'h20, 8'h01);
        note_on(1, 8'h21, 8'h02);
        upd_ready = 1'b0;
        expect_upd(2, 1, 8'h30, 8'h11);
        stall_exp = '{3'd2, 1'b1, 7'h30, 7'h11};
        send(8'h90, 8'h30, 8'h11, 2'd3);
        t = 0;
        while (upd_valid !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("upd_valid_timeout", 0, 1);
        for (int i = 0; i < 10; i++) begin
            check("stall_fields", {upd_valid, upd_voice, upd_gate, upd_note, upd_vel},
                  {1'b1, stall_exp});
            check("stall_msg_ready", msg_ready, 0);
            check("stall_va", voice_active, 8'h03);
            @(posedge clk); #1;
        end
        upd_ready = 1'b1;
        wait_idle();
        check("va_after_stall", voice_active, 8'h07);
        cc_all_off("cc_three");

        expect_upd(0, 1, 8'h45, 8'h33);
        send(8'h90, 8'h50, 8'h22, 2'd3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midscan_upd_valid", upd_valid, 0);
        check("midscan_msg_ready", msg_ready, 0);
        check("midscan_va", voice_active, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midscan_ready", msg_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        send(8'h90, 8'h45, 8'h33, 2'd3);
        wait_idle();
        check("va_post_abort", voice_active, 8'h01);

        repeat (10) @(posedge clk);
        #1;
        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
